// File: rtl/ser_pkg.sv
// -----------------------------------------------------------------------------
// ser_pkg
// Shared widths and the state encoding for the parallel-to-serial stage.
//   DATA_W : width of the parallel word
//   SEL_W  : width of the mux8 bit select
//   GAP_W  : width of the inter-frame gap counter (gap lengths 0..15)
//   state_e: serializer FSM states
// -----------------------------------------------------------------------------
package ser_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned GAP_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

endpackage : ser_pkg

// File: rtl/mux8.sv
// -----------------------------------------------------------------------------
// mux8
// Plain 8:1 combinational multiplexer.
//   sel    : 3-bit select
//   d0..d7 : data inputs
//   y      : selected input (d<sel>)
// -----------------------------------------------------------------------------
module mux8
   import ser_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   input  logic             d0,
   input  logic             d1,
   input  logic             d2,
   input  logic             d3,
   input  logic             d4,
   input  logic             d5,
   input  logic             d6,
   input  logic             d7,
   output logic             y
);

   always_comb begin
      unique case (sel)
         3'd0:    y = d0;
         3'd1:    y = d1;
         3'd2:    y = d2;
         3'd3:    y = d3;
         3'd4:    y = d4;
         3'd5:    y = d5;
         3'd6:    y = d6;
         default: y = d7;
      endcase
   end

endmodule : mux8

// File: rtl/mux8_serializer.sv
// -----------------------------------------------------------------------------
// mux8_serializer
// Accepts an 8-bit word over valid/ready, holds it, and walks a 3-bit select
// through mux8 so the word leaves one bit per cycle, with frame start/end flags.
//   clk        : clock, rising edge
//   reset      : synchronous, active-low reset
//   din        : parallel word
//   din_valid  : din holds a valid word
//   din_ready  : a word can be accepted this cycle
//   sout       : serial bit (0 whenever sout_valid is low)
//   sout_valid : sout carries a frame bit
//   sof / eof  : first / last bit of the frame
//   busy       : FSM is not in IDLE
// Parameters:
//   MSB_FIRST  : 1 = bit 7 first, 0 = bit 0 first
//   GAP_CYCLES : idle cycles forced between frames (0..15)
// -----------------------------------------------------------------------------
module mux8_serializer
   import ser_pkg::*;
#(
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sout,
   output logic              sout_valid,
   output logic              sof,
   output logic              eof,
   output logic              busy
);

   localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(7) : SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? SEL_W'(0) : SEL_W'(7);

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  hold_q,  hold_d;
   logic [SEL_W-1:0]   sel_q,   sel_d;
   logic [GAP_W-1:0]   gap_q,   gap_d;
   logic               mux_y;

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         // NOTE: the hold register is a single word, not a memory array, so it
         // is cheap to clear and gives a known value on the mux inputs.
         hold_q  <= '0;
         sel_q   <= SEL_FIRST;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         sel_q   <= sel_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and no latch is inferred.
      state_d    = state_q;
      hold_d     = hold_q;
      sel_d      = sel_q;
      gap_d      = gap_q;
      din_ready  = 1'b0;
      sout_valid = 1'b0;
      sof        = 1'b0;
      eof        = 1'b0;

      unique case (state_q)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               hold_d  = din;
               sel_d   = SEL_FIRST;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            sout_valid = 1'b1;
            // sel is reloaded at every frame start and steps monotonically,
            // so its value alone identifies the first and last bit.
            sof = (sel_q == SEL_FIRST);
            eof = (sel_q == SEL_LAST);
            if (sel_q == SEL_LAST) begin
               if (GAP_CYCLES == 0) begin
                  // Ready on the last bit so a waiting word follows with no bubble.
                  din_ready = 1'b1;
                  if (din_valid) begin
                     hold_d = din;
                     sel_d  = SEL_FIRST;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = GAP;
                  gap_d   = GAP_W'(GAP_CYCLES);
               end
            end else begin
               sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
            end
         end

         GAP: begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q == GAP_W'(1)) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   mux8 u_mux8 (
      .sel (sel_q),
      .d0  (hold_q[0]),
      .d1  (hold_q[1]),
      .d2  (hold_q[2]),
      .d3  (hold_q[3]),
      .d4  (hold_q[4]),
      .d5  (hold_q[5]),
      .d6  (hold_q[6]),
      .d7  (hold_q[7]),
      .y   (mux_y)
   );

   // Held data would otherwise leak onto the line outside a frame.
   assign sout = mux_y & sout_valid;
   assign busy = (state_q != IDLE);

endmodule : mux8_serializer

// File: tb/tb_mux8_serializer.sv
// -----------------------------------------------------------------------------
// tb_mux8_serializer
// Three instances cover the parameter corners:
//   0: MSB_FIRST=1, GAP_CYCLES=0   1: MSB_FIRST=0, GAP_CYCLES=0
//   2: MSB_FIRST=1, GAP_CYCLES=2
// Expected serial bits are queued when a word is driven and popped by a
// monitor whenever the active instance presents a frame bit.
// -----------------------------------------------------------------------------
module tb_mux8_serializer;

   typedef struct {
      logic bit_v;
      logic sof_v;
      logic eof_v;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [7:0] din        [3];
   logic       din_valid  [3];
   logic       din_ready  [3];
   logic       sout       [3];
   logic       sout_valid [3];
   logic       sof        [3];
   logic       eof        [3];
   logic       busy       [3];

   int   errors = 0;
   int   checks = 0;
   int   act    = 0;
   exp_t exp_q[$];

   mux8_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (
      .clk(clk), .reset(reset), .din(din[0]), .din_valid(din_valid[0]),
      .din_ready(din_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
      .sof(sof[0]), .eof(eof[0]), .busy(busy[0]));

   mux8_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
      .clk(clk), .reset(reset), .din(din[1]), .din_valid(din_valid[1]),
      .din_ready(din_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
      .sof(sof[1]), .eof(eof[1]), .busy(busy[1]));

   mux8_serializer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
      .clk(clk), .reset(reset), .din(din[2]), .din_valid(din_valid[2]),
      .din_ready(din_ready[2]), .sout(sout[2]), .sout_valid(sout_valid[2]),
      .sof(sof[2]), .eof(eof[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Queue the eight expected bits of a frame in output order.
   task automatic push_word(input logic [7:0] word, input bit msb);
      exp_t e;
      for (int b = 0; b < 8; b++) begin
         e.bit_v = word[msb ? (7 - b) : b];
         e.sof_v = (b == 0);
         e.eof_v = (b == 7);
         exp_q.push_back(e);
      end
   endtask

   // Drive a word on an idle instance, check the 8-cycle frame timing and
   // the return to IDLE. Called at a negedge with the instance idle.
   task automatic run_frame(input int idx, input logic [7:0] word, input bit msb);
      chk("ready_before_frame", din_ready[idx], 1);
      din[idx]       = word;
      din_valid[idx] = 1'b1;
      push_word(word, msb);
      @(negedge clk);
      din_valid[idx] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("frame_valid", sout_valid[idx], 1);
         chk("frame_busy", busy[idx], 1);
         @(negedge clk);
      end
      chk("after_frame_valid", sout_valid[idx], 0);
      chk("after_frame_busy", busy[idx], 0);
   endtask

   // Scoreboard monitor, sampling well after the rising edge.
   always @(posedge clk) begin
      exp_t e;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk("sof_and_eof", sof[i] & eof[i], 0);
         chk("sout_gated", sout[i] & ~sout_valid[i], 0);
         if (i != act) chk("inactive_valid", sout_valid[i], 0);
      end
      if (sout_valid[act] === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_bit", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            chk("sout", sout[act], e.bit_v);
            chk("sof", sof[act], e.sof_v);
            chk("eof", eof[act], e.eof_v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din[i]       = 8'hFF;
         din_valid[i] = 1'b1;
      end

      // 1: reset held with a word offered -> nothing accepted.
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk("rst_ready", din_ready[i], 1);
            chk("rst_valid", sout_valid[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_sout", sout[i], 0);
            chk("rst_sof", sof[i], 0);
            chk("rst_eof", eof[i], 0);
         end
      end
      for (int i = 0; i < 3; i++) din_valid[i] = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("post_rst_idle", busy[i], 0);

      // 2: single MSB-first frame.
      act = 0;
      run_frame(0, 8'hA5, 1'b1);

      // 3: back-to-back frames with din_valid held.
      din[0]       = 8'hA5;
      din_valid[0] = 1'b1;
      push_word(8'hA5, 1'b1);
      @(negedge clk);
      din[0] = 8'h3C;
      push_word(8'h3C, 1'b1);
      for (int k = 0; k < 16; k++) begin
         chk("b2b_valid", sout_valid[0], 1);
         chk("b2b_ready", din_ready[0], (k == 7 || k == 15) ? 1 : 0);
         if (k == 8) din_valid[0] = 1'b0;
         @(negedge clk);
      end
      chk("b2b_end_valid", sout_valid[0], 0);
      chk("b2b_end_busy", busy[0], 0);

      // 4: LSB-first frames.
      act = 1;
      run_frame(1, 8'h01, 1'b0);
      run_frame(1, 8'h80, 1'b0);

      // 5: two forced gap cycles between frames.
      act = 2;
      din[2]       = 8'hC3;
      din_valid[2] = 1'b1;
      push_word(8'hC3, 1'b1);
      @(negedge clk);
      din[2] = 8'h5A;
      push_word(8'h5A, 1'b1);
      for (int k = 0; k < 8; k++) begin
         chk("gap_frame_valid", sout_valid[2], 1);
         chk("gap_frame_ready", din_ready[2], 0);
         @(negedge clk);
      end
      repeat (2) begin
         chk("gap_valid", sout_valid[2], 0);
         chk("gap_ready", din_ready[2], 0);
         chk("gap_busy", busy[2], 1);
         @(negedge clk);
      end
      chk("gap_idle_ready", din_ready[2], 1);
      chk("gap_idle_busy", busy[2], 0);
      @(negedge clk);
      din_valid[2] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("gap_frame2_valid", sout_valid[2], 1);
         @(negedge clk);
      end
      chk("gap_end_valid", sout_valid[2], 0);

      // 6: reset during bit 4 aborts the frame and beats a pending handshake.
      act = 0;
      chk("abort_ready_before", din_ready[0], 1);
      din[0]       = 8'hF0;
      din_valid[0] = 1'b1;
      push_word(8'hF0, 1'b1);
      @(negedge clk);
      din_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_bit4_valid", sout_valid[0], 1);
      exp_q.delete();
      reset        = 1'b0;
      din[0]       = 8'h0F;
      din_valid[0] = 1'b1;
      @(negedge clk);
      chk("abort_valid", sout_valid[0], 0);
      chk("abort_sout", sout[0], 0);
      chk("abort_ready", din_ready[0], 1);
      chk("abort_eof", eof[0], 0);
      chk("abort_busy", busy[0], 0);
      reset = 1'b1;
      din_valid[0] = 1'b0;
      run_frame(0, 8'h0F, 1'b1);

      @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mux8_serializer
